slifo_pop_stream: RTL

Downstream drain stage for the synchronous LIFO (`slifo_v2`). It watches `lifo_empty`, issues `rd` pops without ever underflowing the LIFO, and captures the popped words. The words are presented on a valid/ready stream through a 2-entry skid buffer, so the consumer can apply backpressure without loss. It sits directly between the LIFO read port and the consuming logic.

---
 rtl/slifo_pkg.sv | 11 +
 rtl/slifo_skid_buf.sv | 57 +++++
 rtl/slifo_pop_stream.sv | 90 +++++++++
 3 files changed

// File: rtl/slifo_pkg.sv
// Shared constants and types for the LIFO drain stage.
package slifo_pkg;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_COUNT_WIDTH = 16;
    localparam int SKID_DEPTH      = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;
endpackage

// File: rtl/slifo_skid_buf.sv
// 2-entry in-order buffer; a write lands in the same cycle's next-state, head visible next cycle.
// No internal backpressure: the caller guarantees no write while full and no dequeue while empty.
module slifo_skid_buf
    import slifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  deq,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]            occ_q, occ_d;
    logic [1:0]            wr_idx;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        // Write slot is computed after the dequeue shift so a simultaneous pair keeps order.
        wr_idx = occ_q - {1'b0, deq};
        if (deq) begin
            ent0_d = ent1_q;
            occ_d  = occ_d - 2'd1;
        end
        if (wr) begin
            if (wr_idx == 2'd0) begin
                ent0_d = wr_data;
            end else begin
                ent1_d = wr_data;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = ent0_q;

endmodule

// File: rtl/slifo_pop_stream.sv
// LIFO drain stage: pops without underflow into a 2-entry skid, streams words out (optional DRAIN_ON_HIGH_TH_EN burst gating).
// lifo_rd at N gives m_valid at N+2; m_ready low stalls popping once two words are outstanding.
module slifo_pop_stream
    import slifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lifo_empty,
    input  logic                   lifo_high_th,
    input  logic [DATA_WIDTH-1:0]  lifo_data,
    output logic                   lifo_rd,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic [COUNT_WIDTH-1:0] pop_count,
    output logic                   busy
);

    logic                   inflight_q;
    logic [1:0]             occ;
    logic                   deq;
    logic                   drain_active;
    logic [2:0]             credit_used;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    slifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .wr      (inflight_q),
        .wr_data (lifo_data),
        .deq     (deq),
        .occ     (occ),
        .head    (m_data)
    );

    assign m_valid = (occ != 2'd0);
    assign deq     = m_valid && m_ready;

    // Slots already claimed, net of the word leaving this cycle; deq implies occ >= 1.
    assign credit_used = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, deq};
    assign lifo_rd     = !rst && !lifo_empty && drain_active && (credit_used < 3'(SKID_DEPTH));

    assign count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, deq};

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            inflight_q <= lifo_rd;
            count_q    <= count_d;
        end
    end

    assign pop_count = count_q;
    assign busy      = inflight_q || m_valid;

`ifdef DRAIN_ON_HIGH_TH_EN
    drain_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lifo_high_th) state_d = DRAIN;
            DRAIN:   if (lifo_empty && !lifo_rd) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign drain_active = (state_q == DRAIN);
`else
    logic unused_high_th;
    assign unused_high_th = lifo_high_th;
    assign drain_active   = 1'b1;
`endif

endmodule
